// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS multicycle control path.
// Opcodes, ALU op codes and mux selects are shared with the datapath and the ALU control decoder.
package mips_pkg;

  localparam int unsigned OPW  = 6;
  localparam int unsigned SW   = 4;
  localparam int unsigned AOPW = 3;

  typedef enum logic [SW-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [AOPW-1:0] ALUOP_R   = 3'b000;
  localparam logic [AOPW-1:0] ALUOP_ADD = 3'b001;
  localparam logic [AOPW-1:0] ALUOP_SUB = 3'b010;
  localparam logic [AOPW-1:0] ALUOP_AND = 3'b011;
  localparam logic [AOPW-1:0] ALUOP_OR  = 3'b100;
  localparam logic [AOPW-1:0] ALUOP_SLT = 3'b101;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MEM     = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_IMM     = 3'd4,
    CLS_JUMP    = 3'd5
  } op_class_e;

  typedef struct packed {
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [AOPW-1:0] alu_op;
    logic [1:0]      pc_src;
    logic            instr_done;
  } ctrl_t;

  // State-only strobes; imm_op is consulted only for IMMEX.
  function automatic ctrl_t moore_ctrl(input state_e s, input logic [AOPW-1:0] imm_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SL2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_RTEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_R;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALUOP_SUB;
        c.pc_src     = PCSRC_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_IMMEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = imm_op;
      end
      S_IMMWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: opcode/flags in, strobes and debug state out.
interface mips_multicycle_control_if;
  import mips_pkg::*;

  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [AOPW-1:0] alu_op;
  logic [1:0]      pc_src;
  logic            pc_en;
  logic            instr_done;
  logic            illegal;
  logic [SW-1:0]   state;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal, state
  );
endinterface

// File: rtl/mips_ctrl_opdecode.sv
// Combinational opcode classifier: dispatch class, immediate ALU op, bne flag, illegal flag.
module mips_ctrl_opdecode
  import mips_pkg::*;
(
  input  logic [OPW-1:0]  i_opcode,
  output op_class_e       o_cls,
  output logic [AOPW-1:0] o_imm_op,
  output logic            o_is_bne,
  output logic            o_illegal
);

  always_comb begin
    o_cls     = CLS_ILLEGAL;
    o_imm_op  = ALUOP_ADD;
    o_is_bne  = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_LW, OP_SW: o_cls = CLS_MEM;
      OP_RTYPE:     o_cls = CLS_RTYPE;
      OP_BEQ:       o_cls = CLS_BRANCH;
      OP_BNE: begin
        o_cls    = CLS_BRANCH;
        o_is_bne = 1'b1;
      end
      OP_ADDI: begin
        o_cls    = CLS_IMM;
        o_imm_op = ALUOP_ADD;
      end
      OP_ANDI: begin
        o_cls    = CLS_IMM;
        o_imm_op = ALUOP_AND;
      end
      OP_ORI: begin
        o_cls    = CLS_IMM;
        o_imm_op = ALUOP_OR;
      end
      OP_SLTI: begin
        o_cls    = CLS_IMM;
        o_imm_op = ALUOP_SLT;
      end
      OP_J:    o_cls = CLS_JUMP;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// MIPS multicycle main control FSM with PC-enable and branch resolution.
// Define MIPS_CTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  state_e          r_state;
  state_e          w_next;
  ctrl_t           r_ctrl;
  ctrl_t           w_ctrl_next;
  logic            r_is_bne;
  op_class_e       w_cls;
  logic [AOPW-1:0] w_imm_op;
  logic            w_is_bne;
  logic            w_dec_illegal;
  logic            w_mem_go;
  logic            w_pc_en;
  logic            w_ir_write;

  mips_ctrl_opdecode u_opdecode (
    .i_opcode  (bus.opcode),
    .o_cls     (w_cls),
    .o_imm_op  (w_imm_op),
    .o_is_bne  (w_is_bne),
    .o_illegal (w_dec_illegal)
  );

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign w_mem_go = bus.mem_ready;
`else
  assign w_mem_go = 1'b1;
`endif

  // Next-state logic; memory states stall only when w_mem_go is low.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_cls)
          CLS_MEM:    w_next = S_MEMADR;
          CLS_RTYPE:  w_next = S_RTEX;
          CLS_BRANCH: w_next = S_BRANCH;
          CLS_IMM:    w_next = S_IMMEX;
          CLS_JUMP:   w_next = S_JUMP;
          default:    w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mem_go ? S_FETCH : S_MEMWR;
      S_RTEX:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Strobes are precomputed for the next state so they register in step with r_state.
  always_comb begin
    w_ctrl_next = moore_ctrl(w_next, w_imm_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_is_bne <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl_next;
      if (r_state == S_DECODE) r_is_bne <= w_is_bne;
    end
  end

  // PC and IR enables depend on live zero / mem_ready, so they stay combinational.
  always_comb begin
    w_pc_en    = 1'b0;
    w_ir_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_pc_en    = w_mem_go;
        w_ir_write = w_mem_go;
      end
      S_BRANCH: w_pc_en = bus.zero ^ r_is_bne;
      S_JUMP:   w_pc_en = 1'b1;
      default: ;
    endcase
  end

  assign bus.iord       = r_ctrl.iord;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.reg_dst    = r_ctrl.reg_dst;
  assign bus.mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.alu_src_a  = r_ctrl.alu_src_a;
  assign bus.alu_src_b  = r_ctrl.alu_src_b;
  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.pc_src     = r_ctrl.pc_src;
  assign bus.instr_done = r_ctrl.instr_done & (w_mem_go | (r_state != S_MEMWR));
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_en      = w_pc_en;
  assign bus.illegal    = (r_state == S_DECODE) & w_dec_illegal;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle vector table plus reset and memory-wait sequences.
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: iord_mr_mw_irw_rd_m2r_rw_asa_asb_aop_pcs_pcen_done_ill
  localparam logic [17:0] O_IDLE  = 18'b0_0_0_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [17:0] O_FETCH = 18'b0_1_0_1_0_0_0_0_01_001_00_1_0_0;
  localparam logic [17:0] O_DEC   = 18'b0_0_0_0_0_0_0_0_11_001_00_0_0_0;
  localparam logic [17:0] O_DILL  = 18'b0_0_0_0_0_0_0_0_11_001_00_0_0_1;
  localparam logic [17:0] O_MADR  = 18'b0_0_0_0_0_0_0_1_10_001_00_0_0_0;
  localparam logic [17:0] O_MRD   = 18'b1_1_0_0_0_0_0_0_00_000_00_0_0_0;
  localparam logic [17:0] O_MWB   = 18'b0_0_0_0_0_1_1_0_00_000_00_0_1_0;
  localparam logic [17:0] O_MWR   = 18'b1_0_1_0_0_0_0_0_00_000_00_0_1_0;
  localparam logic [17:0] O_RTEX  = 18'b0_0_0_0_0_0_0_1_00_000_00_0_0_0;
  localparam logic [17:0] O_AWB   = 18'b0_0_0_0_1_0_1_0_00_000_00_0_1_0;
  localparam logic [17:0] O_BRT   = 18'b0_0_0_0_0_0_0_1_00_010_01_1_1_0;
  localparam logic [17:0] O_BRN   = 18'b0_0_0_0_0_0_0_1_00_010_01_0_1_0;
  localparam logic [17:0] O_IXOR  = 18'b0_0_0_0_0_0_0_1_10_100_00_0_0_0;
  localparam logic [17:0] O_IXAD  = 18'b0_0_0_0_0_0_0_1_10_001_00_0_0_0;
  localparam logic [17:0] O_IXAN  = 18'b0_0_0_0_0_0_0_1_10_011_00_0_0_0;
  localparam logic [17:0] O_IXSL  = 18'b0_0_0_0_0_0_0_1_10_101_00_0_0_0;
  localparam logic [17:0] O_IWB   = 18'b0_0_0_0_0_0_1_0_00_000_00_0_1_0;
  localparam logic [17:0] O_JMP   = 18'b0_0_0_0_0_0_0_0_00_000_10_1_1_0;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  function automatic logic [17:0] outs();
    return {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.pc_en, bus.instr_done, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic [3:0] st,
                     input logic [17:0] o);
    vec_t v;
    v.op = op; v.z = z; v.st = st; v.out = o;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n          = 1'b0;
    bus.opcode     = 6'b000000;
    bus.zero       = 1'b0;
    bus.mem_ready  = 1'b1;

    // R-type from reset: IDLE once, then 4 cycles
    add(6'b000000, 0, 4'd0,  O_IDLE);
    add(6'b000000, 0, 4'd1,  O_FETCH);
    add(6'b000000, 0, 4'd2,  O_DEC);
    add(6'b000000, 0, 4'd7,  O_RTEX);
    add(6'b000000, 0, 4'd8,  O_AWB);
    // lw
    add(6'b100011, 0, 4'd1,  O_FETCH);
    add(6'b100011, 0, 4'd2,  O_DEC);
    add(6'b100011, 0, 4'd3,  O_MADR);
    add(6'b100011, 0, 4'd4,  O_MRD);
    add(6'b100011, 0, 4'd5,  O_MWB);
    // beq/bne with zero=1 and zero=0
    add(6'b000100, 1, 4'd1,  O_FETCH);
    add(6'b000100, 1, 4'd2,  O_DEC);
    add(6'b000100, 1, 4'd9,  O_BRT);
    add(6'b000101, 1, 4'd1,  O_FETCH);
    add(6'b000101, 1, 4'd2,  O_DEC);
    add(6'b000101, 1, 4'd9,  O_BRN);
    add(6'b000100, 0, 4'd1,  O_FETCH);
    add(6'b000100, 0, 4'd2,  O_DEC);
    add(6'b000100, 0, 4'd9,  O_BRN);
    add(6'b000101, 0, 4'd1,  O_FETCH);
    add(6'b000101, 0, 4'd2,  O_DEC);
    add(6'b000101, 0, 4'd9,  O_BRT);
    // immediates
    add(6'b001101, 0, 4'd1,  O_FETCH);
    add(6'b001101, 0, 4'd2,  O_DEC);
    add(6'b001101, 0, 4'd10, O_IXOR);
    add(6'b001101, 0, 4'd11, O_IWB);
    add(6'b001000, 0, 4'd2,  O_FETCH & 18'h0 | O_DEC);
    vecs.pop_back();
    add(6'b001000, 0, 4'd1,  O_FETCH);
    add(6'b001000, 0, 4'd2,  O_DEC);
    add(6'b001000, 0, 4'd10, O_IXAD);
    add(6'b001000, 0, 4'd11, O_IWB);
    add(6'b001100, 0, 4'd1,  O_FETCH);
    add(6'b001100, 0, 4'd2,  O_DEC);
    add(6'b001100, 0, 4'd10, O_IXAN);
    add(6'b001100, 0, 4'd11, O_IWB);
    add(6'b001010, 0, 4'd1,  O_FETCH);
    add(6'b001010, 0, 4'd2,  O_DEC);
    add(6'b001010, 0, 4'd10, O_IXSL);
    add(6'b001010, 0, 4'd11, O_IWB);
    // illegal opcode returns straight to FETCH
    add(6'b111111, 0, 4'd1,  O_FETCH);
    add(6'b111111, 0, 4'd2,  O_DILL);
    // j
    add(6'b000010, 0, 4'd1,  O_FETCH);
    add(6'b000010, 0, 4'd2,  O_DEC);
    add(6'b000010, 0, 4'd12, O_JMP);
    // sw
    add(6'b101011, 0, 4'd1,  O_FETCH);
    add(6'b101011, 0, 4'd2,  O_DEC);
    add(6'b101011, 0, 4'd3,  O_MADR);
    add(6'b101011, 0, 4'd6,  O_MWR);
    add(6'b101011, 0, 4'd1,  O_FETCH);

    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 18'(bus.state), 18'd0);
    check("reset_outs", outs(), O_IDLE);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op;
      bus.zero   = vecs[i].z;
      #1;
      check($sformatf("row%0d_state", i), 18'(bus.state), 18'(vecs[i].st));
      check($sformatf("row%0d_outs", i), outs(), vecs[i].out);
      if (bus.mem_write && bus.reg_write) check($sformatf("row%0d_mw_rw", i), 18'd1, 18'd0);
      @(negedge clk);
    end

    // Asynchronous reset while in MEMWR
    begin
      bit found;
      found = 1'b0;
      bus.opcode = 6'b101011;
      for (int k = 0; k < 12 && !found; k++) begin
        #1;
        if (bus.state == 4'd6) found = 1'b1;
        else @(negedge clk);
      end
      if (!found) check("reach_memwr_timeout", 18'd0, 18'd1);
      check("memwr_mem_write_before_rst", 18'(bus.mem_write), 18'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_state", 18'(bus.state), 18'd0);
      check("async_rst_outs", outs(), O_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_idle", 18'(bus.state), 18'd0);
      @(negedge clk);
    end

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // FETCH stall, then sw with MEMWR held for 3 not-ready cycles
    bus.mem_ready = 1'b0;
    #1;
    check("wfetch_state", 18'(bus.state), 18'd1);
    check("wfetch_outs", outs(), 18'b0_1_0_0_0_0_0_0_01_001_00_0_0_0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("wfetch_held_state", 18'(bus.state), 18'd1);
    check("wfetch_ready_outs", outs(), O_FETCH);
    @(negedge clk);
    #1 check("w_decode", 18'(bus.state), 18'd2);
    @(negedge clk);
    #1 check("w_memadr", 18'(bus.state), 18'd3);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("wmemwr%0d_state", k), 18'(bus.state), 18'd6);
      check($sformatf("wmemwr%0d_outs", k), outs(), 18'b1_0_1_0_0_0_0_0_00_000_00_0_0_0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    #1;
    check("wmemwr_ready_state", 18'(bus.state), 18'd6);
    check("wmemwr_ready_outs", outs(), O_MWR);
    @(negedge clk);
    #1 check("wmemwr_exit", 18'(bus.state), 18'd1);
`else
    // mem_ready is ignored: FETCH completes and advances regardless
    bus.mem_ready = 1'b0;
    #1;
    check("nw_fetch_state", 18'(bus.state), 18'd1);
    check("nw_fetch_outs", outs(), O_FETCH);
    @(negedge clk);
    #1 check("nw_decode", 18'(bus.state), 18'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath strobes.
- Produces the 3-bit alu_op code consumed directly by the downstream ALU control decoder. That decoder maps alu_op + funct to the ALU function.
- Also owns the PC-enable logic, including branch resolution from the ALU zero flag.

Parameters:
- OPW, 6: opcode width.
- SW, 4: state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN).
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  3  000 R-type(funct), 001 add, 010 sub, 011 and, 100 or, 101 slt.
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- pc_en  out  1  PC write enable.
- instr_done  out  1  one-cycle pulse in each instruction's final state.
- illegal  out  1  one-cycle pulse on unknown opcode.
- state  out  SW  current state, for debug.

Behaviour:
- Clock and reset: single clock, asynchronous active-low reset rst_n. Reset forces state = IDLE.
- Outputs: Moore-style decode of the state register, except pc_en (uses zero and mem_ready) and ir_write (uses mem_ready).
- Default: any strobe not listed for a state is 0.
- State encoding (SW bits): IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTEX 7, ALUWB 8, BRANCH 9, IMMEX 10, IMMWB 11, JUMP 12. Codes 13-15 are unreachable and recover to FETCH.
- IDLE: all outputs 0; these are the reset values. Next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=001, pc_src=00; ir_write=pc_en=1. Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=001 (branch target into ALUOut).
  - Latches imm_op: addi 001, andi 011, ori 100, slti 101.
  - Latches is_bne.
  - Dispatch by opcode: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> RTEX; beq 000100 / bne 000101 -> BRANCH; addi 001000 / andi 001100 / ori 001101 / slti 001010 -> IMMEX; j 000010 -> JUMP.
  - Any other opcode: illegal=1, next state FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=001. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Next state MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1, instr_done=1. Next state FETCH.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=000. Next state ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_src=01, instr_done=1. pc_en = zero XOR is_bne. Next state FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, alu_op=imm_op. Next state IMMWB.
- IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next state FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Next state FETCH.
- CPI: lw 5, sw 4, R-type 4, imm 4, beq/bne 3, j 3 cycles. The single IDLE cycle occurs only after reset.
- Reset mid-instruction: immediate return to IDLE; no strobe persists.
- mem_write and reg_write are never both 1 in the same cycle.

Optional Feature:
- Macro: MIPS_CTRL_MEM_WAIT_EN.
- With the macro defined: FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - FETCH asserts ir_write and pc_en only in the cycle with mem_ready=1.
  - MEMWR asserts instr_done only when mem_ready=1.
  - mem_read/mem_write stay high throughout the wait.
- Without the macro: mem_ready is ignored and each memory state takes exactly one cycle.

Decomposition:
- Shared package mips_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J);
  - alu_op codes (ALUOP_R, ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_SLT), shared with the ALU control decoder;
  - alu_src_b and pc_src codes.
- One sub-module: mips_ctrl_opdecode, combinational. It maps opcode to {next-state class, imm_op, is_bne, illegal}.

Test Plan:
- Reset release, then opcode=000000 -> IDLE 1 cycle; FETCH shows pc_en=1, ir_write=1, alu_op=001; RTEX alu_op=000; ALUWB reg_write=1, reg_dst=1; instr_done after 4 cycles.
- lw (100011) -> state sequence 1,2,3,4,5; MEMRD iord=1; MEMWB mem_to_reg=1.
- beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH. bne with zero=1 -> pc_en=0.
- ori (001101) -> IMMEX alu_op=100, alu_src_b=10; IMMWB reg_write=1, reg_dst=0.
- opcode=111111 -> illegal pulse in DECODE, return to FETCH, no reg_write/mem_write. Separately, rst_n low during MEMWR -> mem_write drops asynchronously, state=0.
- With MIPS_CTRL_MEM_WAIT_EN: sw holding mem_ready=0 for 3 cycles -> MEMWR held 4 cycles with mem_write=1; instr_done only on the ready cycle.
